// File: rtl/pmod_als_spi_master_pkg.sv
// Shared types and helpers for the PmodALS SPI master: FSM state encoding,
// LED count and the bargraph renderer.
package pmod_als_spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    localparam int BAR_LEDS = 16;

    // Lights LEDs 0..top inclusive; a zero reading turns every LED off.
    function automatic logic [BAR_LEDS-1:0] bar_render(input logic [3:0] top,
                                                       input logic       nonzero);
        logic [BAR_LEDS-1:0] bar;
        bar = '0;
        for (int i = 0; i < BAR_LEDS; i++) begin
            bar[i] = nonzero && (i <= int'(top));
        end
        return bar;
    endfunction

endpackage

// File: rtl/pmod_als_spi_master_sclk_gen.sv
// SPI clock generator: a half-period counter that toggles sclk (CPOL=1) and
// reports rise/fall strobes plus the number of rising edges in the frame.
module pmod_als_spi_master_sclk_gen #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              run,
    output logic                              sclk,
    output logic                              half_tick,
    output logic                              rise_tick,
    output logic                              fall_tick,
    output logic [$clog2(FRAME_BITS+1)-1:0]   edge_cnt
);

    localparam int HW = $clog2(CLK_DIV);
    localparam int EW = $clog2(FRAME_BITS + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(FRAME_BITS);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          sclk_q, sclk_d;
    logic [EW-1:0] edge_q, edge_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        half_tick = run && (hcnt_q == HALF_LAST);
        rise_tick = half_tick && !sclk_q;
        // Once the last rising edge is done sclk stays high for the hold phase.
        fall_tick = half_tick && sclk_q && (edge_q != LAST_EDGE);
        hcnt_d    = '0;
        sclk_d    = 1'b1;
        edge_d    = '0;
        if (run) begin
            hcnt_d = half_tick ? '0 : hcnt_q + HW'(1);
            sclk_d = sclk_q ^ (rise_tick || fall_tick);
            edge_d = edge_q + EW'(rise_tick);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            sclk_q <= 1'b1;
            edge_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            sclk_q <= sclk_d;
            edge_q <= edge_d;
        end
    end

    assign sclk     = sclk_q;
    assign edge_cnt = edge_q;

endmodule

// File: rtl/pmod_als_spi_master.sv
// Self-timed SPI master for ADC081S021-style light sensors: frame FSM, shift
// register, data-field extract, periodic auto-sampling and LED rendering.
module pmod_als_spi_master
    import pmod_als_spi_master_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16,
    parameter int DATA_MSB   = 12,
    parameter int DATA_LSB   = 5,
    parameter int CS_GAP     = 8,
    parameter int PERIOD_W   = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         miso,
    input  logic                         start,
    input  logic                         auto_en,
    input  logic [PERIOD_W-1:0]          sample_period,
    input  logic                         bar_mode,
    output logic                         sclk,
    output logic                         cs_n,
    output logic                         busy,
    output logic [DATA_MSB-DATA_LSB:0]   data,
    output logic [FRAME_BITS-1:0]        frame_raw,
    output logic                         data_valid,
    output logic [BAR_LEDS-1:0]          led
);

    localparam int DW = DATA_MSB - DATA_LSB + 1;
    localparam int EW = $clog2(FRAME_BITS + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(FRAME_BITS);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

    spi_state_e              state_q, state_d;
    logic                    cs_n_q, cs_n_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [DW-1:0]           data_q, data_d;
    logic                    dv_q, dv_d;
    logic [BAR_LEDS-1:0]     led_q, led_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [PERIOD_W-1:0]     per_q, per_d;
    logic                    pend_q, pend_d;

    logic                    gen_run;
    logic                    half_tick, rise_tick, fall_tick;
    logic [EW-1:0]           edge_cnt;
    logic [PERIOD_W-1:0]     per_last;
    logic                    auto_tick;
    logic [BAR_LEDS-1:0]     led_raw;

    assign gen_run = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

    pmod_als_spi_master_sclk_gen #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (gen_run),
        .sclk      (sclk),
        .half_tick (half_tick),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .edge_cnt  (edge_cnt)
    );

    // Auto timer: a period of 0 or 1 degenerates to a tick every clock.
    always_comb begin
        per_last  = (sample_period > PERIOD_W'(1)) ? sample_period - PERIOD_W'(1) : '0;
        auto_tick = auto_en && (per_q >= per_last);
        per_d     = (!auto_en || auto_tick) ? '0 : per_q + PERIOD_W'(1);
        pend_d    = '0;
        if (auto_en && (state_q != ST_IDLE)) begin
            pend_d = pend_q || auto_tick;
        end
    end

    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        shift_d = shift_q;
        frame_d = frame_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        gap_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                // start and an auto tick arriving together launch a single frame.
                if (start || auto_tick || pend_q) begin
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                if (fall_tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rise_tick) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], miso};
                end
                if (half_tick && (edge_cnt == LAST_EDGE)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (half_tick) begin
                    state_d = ST_GAP;
                    cs_n_d  = 1'b1;
                    frame_d = shift_q;
                    data_d  = shift_q[DATA_MSB:DATA_LSB];
                    dv_d    = 1'b1;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    // led is re-rendered every clock so a bar_mode change shows on the next edge.
    assign led_raw = BAR_LEDS'(data_q);
    assign led_d   = bar_mode ? bar_render(data_q[DW-1 -: 4], |data_q) : led_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cs_n_q  <= 1'b1;
            shift_q <= '0;
            frame_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            led_q   <= '0;
            gap_q   <= '0;
            per_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            shift_q <= shift_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            led_q   <= led_d;
            gap_q   <= gap_d;
            per_q   <= per_d;
            pend_q  <= pend_d;
        end
    end

    assign cs_n       = cs_n_q;
    assign busy       = (state_q != ST_IDLE);
    assign data       = data_q;
    assign frame_raw  = frame_q;
    assign data_valid = dv_q;
    assign led        = led_q;

endmodule
